alu_control: RTL and testbench
==============================

ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-003 SHALL have port start  input  1  one-cycle operation request, qualified with funct.
REQ-004 SHALL have port funct  input  6  operation code: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SLL 000000, MULTU 011001, MFHI 010000, MFLO 010010.
REQ-005 SHALL have port SignaltoALU  output  6  code to ALU; NOP (111111) when not in use.
REQ-006 SHALL have port SignaltoSHT  output  6  code to shifter; NOP when not in use.
REQ-007 SHALL have port SignaltoMULTU  output  6  code to multiplier; NOP when not in use.
REQ-008 SHALL have port SignaltoMUX  output  6  select code to the output MUX; NOP when idle.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the result is valid at the MUX.
REQ-011 SHALL have port hilo_we  output  1  one-cycle HI/LO write-enable at multiply completion.
REQ-012 SHALL have port illegal  output  1  one-cycle pulse for an unsupported funct.

Function
REQ-013 SHALL register all outputs; no combinational path from start/funct to any output.
REQ-014 SHALL implement states IDLE, SINGLE, MULT; encoding free.
REQ-015 SHALL, in IDLE with start=1 and funct in {AND, OR, ADD, SUB, SLT}, drive SignaltoALU=funct and SignaltoMUX=funct the next cycle, with done=1 and busy=1 that cycle (state SINGLE), then return to IDLE.
REQ-016 SHALL, for funct=SLL, drive SignaltoSHT=SLL and SignaltoMUX=SLL with the same one-cycle timing as REQ-015.
REQ-017 SHALL, for funct in {MFHI, MFLO}, drive SignaltoMUX=funct only (ALU/SHT/MULTU stay NOP) with the same one-cycle timing.
REQ-018 SHALL, for funct=MULTU, enter MULT, hold SignaltoMULTU=MULTU and busy=1 for exactly 32 cycles, counted by a 6-bit counter running 0..31.
REQ-019 SHALL, in the 32nd MULT cycle (counter=31), pulse hilo_we=1 and done=1, then return to IDLE with SignaltoMULTU=NOP on the following cycle.
REQ-020 SHALL keep SignaltoMUX=NOP throughout MULT; MULTU produces no MUX result.
REQ-021 SHALL ignore start while busy=1: no queuing, no effect on state, counter or outputs.
REQ-022 SHALL, for start with an unsupported funct, pulse illegal=1 and done=1 the next cycle, keep all Signal outputs NOP, keep busy=0, and stay in IDLE.
REQ-023 SHALL return every Signal output to NOP, and done to 0, in the cycle after any done pulse unless a new start was accepted.
REQ-024 SHALL accept back-to-back single-cycle ops: a start in the cycle where done=1 for a single-cycle op is ignored (busy=1); the next start is accepted one cycle later.
REQ-025 SHALL hold all outputs stable while start=0 and state is IDLE.

Reset
REQ-026 SHALL, with reset=1 at a clk edge, enter IDLE, clear the counter, set all Signal outputs to NOP, and set busy, done, hilo_we and illegal to 0.
REQ-027 SHALL give reset priority over start and over any in-progress MULT; an aborted multiply never pulses hilo_we or done.
REQ-028 SHALL accept a start in the first cycle after reset deasserts.

Verification
REQ-029 SHALL be verified for ADD: start=1, funct=100000 -> next cycle SignaltoALU=100000, SignaltoMUX=100000, done=1; the following cycle all Signal outputs=111111, busy=0.
REQ-030 SHALL be verified for SLL: start=1, funct=000000 -> next cycle SignaltoSHT=000000, SignaltoMUX=000000, SignaltoALU=111111, done=1.
REQ-031 SHALL be verified for MULTU: start=1, funct=011001 -> SignaltoMULTU=011001 and busy=1 for 32 cycles; hilo_we=done=1 only in cycle 32; MFHI issued afterwards -> SignaltoMUX=010000 one cycle later.
REQ-032 SHALL be verified for start while busy: ADD issued in MULT cycle 10 -> ignored, MULTU completes in cycle 32 unchanged, no ALU activity.
REQ-033 SHALL be verified for reset mid-multiply: reset in MULT cycle 20 -> next cycle all outputs NOP/0, no hilo_we; a fresh MULTU then takes the full 32 cycles.
REQ-034 SHALL be verified for an illegal code: start=1, funct=111000 -> next cycle illegal=1, done=1, busy=0, all Signal outputs 111111.

Source files
------------

// File: rtl/alu_control.sv
// ALU control sequencer: decodes a requested funct into per-unit command codes
// for the ALU, shifter and multiplier and a select code for the result MUX.
// Single-cycle ops finish in one cycle. MULTU occupies 32 cycles and ends with
// a HI/LO write. Every output is a register, so start/funct never reach an
// output combinationally.
module alu_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] funct,
  output logic [5:0] SignaltoALU,
  output logic [5:0] SignaltoSHT,
  output logic [5:0] SignaltoMULTU,
  output logic [5:0] SignaltoMUX,
  output logic       busy,
  output logic       done,
  output logic       hilo_we,
  output logic       illegal
);

  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] NOP      = 6'b111111;

  // The final multiply cycle is the one where the counter reads this value.
  localparam logic [5:0] MULT_LAST = 6'd31;

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    MULT
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [5:0] count;
  logic [5:0] count_next;
  logic [5:0] alu_next;
  logic [5:0] sht_next;
  logic [5:0] multu_next;
  logic [5:0] mux_next;
  logic       busy_next;
  logic       done_next;
  logic       hilo_next;
  logic       illegal_next;

  // State, counter and all outputs register the values decided below.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= 6'd0;
      SignaltoALU   <= NOP;
      SignaltoSHT   <= NOP;
      SignaltoMULTU <= NOP;
      SignaltoMUX   <= NOP;
      busy          <= 1'b0;
      done          <= 1'b0;
      hilo_we       <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      SignaltoALU   <= alu_next;
      SignaltoSHT   <= sht_next;
      SignaltoMULTU <= multu_next;
      SignaltoMUX   <= mux_next;
      busy          <= busy_next;
      done          <= done_next;
      hilo_we       <= hilo_next;
      illegal       <= illegal_next;
    end
  end

  // Next-state and next-output decode; everything idles at NOP/0 unless a case claims it.
  always_comb begin
    state_next   = state;
    count_next   = count;
    alu_next     = NOP;
    sht_next     = NOP;
    multu_next   = NOP;
    mux_next     = NOP;
    busy_next    = 1'b0;
    done_next    = 1'b0;
    hilo_next    = 1'b0;
    illegal_next = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          case (funct)
            FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: begin
              state_next = SINGLE;
              alu_next   = funct;
              mux_next   = funct;
              busy_next  = 1'b1;
              done_next  = 1'b1;
            end
            FN_SLL: begin
              state_next = SINGLE;
              sht_next   = funct;
              mux_next   = funct;
              busy_next  = 1'b1;
              done_next  = 1'b1;
            end
            FN_MFHI, FN_MFLO: begin
              state_next = SINGLE;
              mux_next   = funct;
              busy_next  = 1'b1;
              done_next  = 1'b1;
            end
            FN_MULTU: begin
              state_next = MULT;
              count_next = 6'd0;
              multu_next = FN_MULTU;
              busy_next  = 1'b1;
            end
            default: begin
              // Unsupported code: flag it and finish at once without leaving IDLE.
              illegal_next = 1'b1;
              done_next    = 1'b1;
            end
          endcase
        end
      end

      SINGLE: begin
        // The result was presented this cycle; a start arriving now is dropped.
        state_next = IDLE;
      end

      MULT: begin
        if (count == MULT_LAST) begin
          state_next = IDLE;
          count_next = 6'd0;
        end else begin
          count_next = count + 6'd1;
          multu_next = FN_MULTU;
          busy_next  = 1'b1;
          // The registered outputs show next cycle's values, so the
          // completion pulse is raised while the counter still reads 30.
          if (count == MULT_LAST - 6'd1) begin
            hilo_next = 1'b1;
            done_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        count_next = 6'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed vectors, expected done-cycle
// responses queued on issue and checked by an independent monitor, plus
// cycle-exact output checks from the stimulus thread.
module tb_alu_control;

  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_BAD   = 6'b111000;
  localparam logic [5:0] NOP      = 6'b111111;

  logic       clk;
  logic       reset;
  logic       start;
  logic [5:0] funct;
  logic [5:0] SignaltoALU;
  logic [5:0] SignaltoSHT;
  logic [5:0] SignaltoMULTU;
  logic [5:0] SignaltoMUX;
  logic       busy;
  logic       done;
  logic       hilo_we;
  logic       illegal;

  int checks = 0;
  int failures = 0;
  logic [27:0] sb[$];

  alu_control dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .funct        (funct),
    .SignaltoALU  (SignaltoALU),
    .SignaltoSHT  (SignaltoSHT),
    .SignaltoMULTU(SignaltoMULTU),
    .SignaltoMUX  (SignaltoMUX),
    .busy         (busy),
    .done         (done),
    .hilo_we      (hilo_we),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout: {ALU, SHT, MULTU, MUX, busy, done, hilo_we, illegal}
  function automatic logic [27:0] exp_vec(input logic [5:0] alu, input logic [5:0] sht,
                                          input logic [5:0] multu, input logic [5:0] mux,
                                          input logic b, input logic d,
                                          input logic h, input logic i);
    return {alu, sht, multu, mux, b, d, h, i};
  endfunction

  function automatic logic [27:0] act_vec();
    return {SignaltoALU, SignaltoSHT, SignaltoMULTU, SignaltoMUX, busy, done, hilo_we, illegal};
  endfunction

  localparam logic [27:0] IDLE_VEC = {NOP, NOP, NOP, NOP, 4'b0000};

  task automatic checkOutput(input string name, input logic [27:0] expected);
    logic [27:0] got;
    got = act_vec();
    checks++;
    if (got !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b required %b", name, got, expected);
    end
  endtask

  // Raise start for one cycle with the given funct; optionally queue the done-cycle response.
  task automatic applyStimulus(input logic [5:0] f, input logic [27:0] expected, input bit push);
    start = 1'b1;
    funct = f;
    if (push) sb.push_back(expected);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Issue MULTU and check every cycle; optionally inject an ADD or a reset at a given cycle.
  task automatic runMult(input int ignore_at, input int reset_at);
    bit aborted;
    aborted = 1'b0;
    applyStimulus(FN_MULTU, exp_vec(NOP, NOP, FN_MULTU, NOP, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1);
    for (int c = 1; c <= 32 && !aborted; c++) begin
      checkOutput($sformatf("mult_cycle%0d", c),
                  exp_vec(NOP, NOP, FN_MULTU, NOP, 1'b1, c == 32, c == 32, 1'b0));
      if (c == reset_at) begin
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        checkOutput("mult_reset_abort", IDLE_VEC);
        reset = 1'b0;
        aborted = 1'b1;
      end else begin
        if (c == ignore_at) begin
          start = 1'b1;
          funct = FN_ADD;
        end
        @(negedge clk);
        start = 1'b0;
      end
    end
    checkOutput(aborted ? "mult_after_abort" : "mult_after_done", IDLE_VEC);
  endtask

  // Monitor: every done pulse must match the oldest queued response.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_unexpected_done: got %b required no done pulse", act_vec());
      end else begin
        logic [27:0] expected;
        expected = sb.pop_front();
        if (act_vec() !== expected) begin
          failures++;
          $display("[TB] FAIL sb_done_response: got %b required %b", act_vec(), expected);
        end
      end
    end
  end

  // Directed single-cycle ops: funct, expected ALU, SHT, MUX codes on the done cycle.
  logic [5:0] single_f   [4] = '{FN_OR, FN_SLT, FN_SLL, FN_MFLO};
  logic [5:0] single_alu [4] = '{FN_OR, FN_SLT, NOP, NOP};
  logic [5:0] single_sht [4] = '{NOP, NOP, FN_SLL, NOP};
  logic [5:0] single_mux [4] = '{FN_OR, FN_SLT, FN_SLL, FN_MFLO};

  initial begin
    reset = 1'b1;
    start = 1'b0;
    funct = FN_AND;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", IDLE_VEC);

    // ADD issued in the very first cycle after reset releases.
    reset = 1'b0;
    applyStimulus(FN_ADD, exp_vec(FN_ADD, NOP, NOP, FN_ADD, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
    checkOutput("add_result", exp_vec(FN_ADD, NOP, NOP, FN_ADD, 1'b1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    checkOutput("add_return_idle", IDLE_VEC);

    // Idle with start low: outputs hold.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idle_hold", IDLE_VEC);
    end

    // Back-to-back: OR during AND's done cycle is dropped, SUB one cycle later is taken.
    applyStimulus(FN_AND, exp_vec(FN_AND, NOP, NOP, FN_AND, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
    checkOutput("b2b_and", exp_vec(FN_AND, NOP, NOP, FN_AND, 1'b1, 1'b1, 1'b0, 1'b0));
    applyStimulus(FN_OR, IDLE_VEC, 1'b0);
    checkOutput("b2b_or_ignored", IDLE_VEC);
    applyStimulus(FN_SUB, exp_vec(FN_SUB, NOP, NOP, FN_SUB, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
    checkOutput("b2b_sub", exp_vec(FN_SUB, NOP, NOP, FN_SUB, 1'b1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    checkOutput("b2b_idle", IDLE_VEC);

    for (int i = 0; i < 4; i++) begin
      logic [27:0] e;
      e = exp_vec(single_alu[i], single_sht[i], NOP, single_mux[i], 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(single_f[i], e, 1'b1);
      checkOutput($sformatf("single_op%0d", i), e);
      @(negedge clk);
      checkOutput($sformatf("single_op%0d_idle", i), IDLE_VEC);
    end

    // Unsupported code.
    applyStimulus(FN_BAD, exp_vec(NOP, NOP, NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1);
    checkOutput("illegal_pulse", exp_vec(NOP, NOP, NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b1));
    @(negedge clk);
    checkOutput("illegal_idle", IDLE_VEC);

    // Full multiply, then read HI.
    runMult(0, 0);
    applyStimulus(FN_MFHI, exp_vec(NOP, NOP, NOP, FN_MFHI, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1);
    checkOutput("mfhi_after_mult", exp_vec(NOP, NOP, NOP, FN_MFHI, 1'b1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    checkOutput("mfhi_idle", IDLE_VEC);

    // ADD during cycle 10 of a multiply is ignored.
    runMult(10, 0);

    // Reset during cycle 20 aborts; a later multiply runs the full length.
    runMult(0, 20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_abort_quiet", IDLE_VEC);
    end
    runMult(0, 0);

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_pending: got %0d queued responses required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
